// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned ROW_W    = 2;
    localparam int unsigned COL_W    = 2;
    localparam int unsigned CODE_W   = ROW_W + COL_W;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        FRAME_NONE   = 2'd0,
        FRAME_SINGLE = 2'd1,
        FRAME_MULTI  = 2'd2
    } frame_class_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_PRESSED = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Closure count is saturated at 2, so 2 or more means several keys.
    function automatic frame_class_e frame_class_of(input logic [1:0] closures);
        case (closures)
            2'd0:    return FRAME_NONE;
            2'd1:    return FRAME_SINGLE;
            default: return FRAME_MULTI;
        endcase
    endfunction

endpackage

// File: rtl/kp_frame_scan.sv
// Column drive, per-column row sampling and whole-frame classification.
// Frame result is valid combinationally during the tick that closes the frame.
module kp_frame_scan
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_tick,
    input  logic [NUM_ROWS-1:0] row_sync,
    output logic [NUM_COLS-1:0] keyboard_col,
    output logic                frame_done,
    output frame_class_e        frame_class,
    output logic [CODE_W-1:0]   frame_code
);

    logic [COL_W-1:0]    index_q, index_d;
    logic [NUM_COLS-1:0] col_q;
    logic [1:0]          acc_cnt_q, acc_cnt_d;
    logic [CODE_W-1:0]   acc_code_q, code_d;
    logic [1:0]          hits;
    logic [ROW_W-1:0]    hit_row;

    // Closures on the currently driven column, saturated at 2.
    always_comb begin
        hits    = 2'd0;
        hit_row = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!row_sync[r]) begin
                if (hits == 2'd0) hit_row = ROW_W'(r);
                if (hits != 2'd2) hits = hits + 2'd1;
            end
        end
    end

    always_comb begin
        index_d = index_q + COL_W'(1);
        if (acc_cnt_q == 2'd0)      acc_cnt_d = hits;
        else if (acc_cnt_q == 2'd1) acc_cnt_d = (hits == 2'd0) ? 2'd1 : 2'd2;
        else                        acc_cnt_d = 2'd2;
        code_d = (acc_cnt_q == 2'd1) ? acc_code_q : {hit_row, index_q};
    end

    assign frame_done   = scan_tick && (index_q == COL_W'(NUM_COLS - 1));
    assign frame_class  = frame_class_of(acc_cnt_d);
    assign frame_code   = code_d;
    assign keyboard_col = col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q    <= '0;
            col_q      <= {{(NUM_COLS - 1){1'b1}}, 1'b0};
            acc_cnt_q  <= 2'd0;
            acc_code_q <= '0;
        end else if (scan_tick) begin
            index_q <= index_d;
            col_q   <= ~(NUM_COLS'(1) << index_d);
            if (frame_done) begin
                acc_cnt_q  <= 2'd0;
                acc_code_q <= '0;
            end else begin
                acc_cnt_q  <= acc_cnt_d;
                acc_code_q <= code_d;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchronizer, frame scanner and press/release debounce FSM.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_tick,
    input  logic [NUM_ROWS-1:0] keyboard_row,
    output logic [NUM_COLS-1:0] keyboard_col,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_pressed
);

    localparam logic [CNT_W-1:0] DF_C = CNT_W'(DEBOUNCE_FRAMES);

    logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
    logic                frame_done;
    frame_class_e        frame_class;
    logic [CODE_W-1:0]   frame_code;

    state_e              state_q;
    logic [CODE_W-1:0]   cand_q, key_code_q;
    logic [CNT_W-1:0]    cnt_q, cnt_inc;
    logic                key_valid_q, key_pressed_q;
    logic                is_none, is_single, same_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= keyboard_row;
            row_sync_q <= row_meta_q;
        end
    end

    kp_frame_scan u_frame_scan (
        .clk          (clk),
        .rst          (rst),
        .scan_tick    (scan_tick),
        .row_sync     (row_sync_q),
        .keyboard_col (keyboard_col),
        .frame_done   (frame_done),
        .frame_class  (frame_class),
        .frame_code   (frame_code)
    );

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign is_none   = (frame_class == FRAME_NONE);
    assign is_single = (frame_class == FRAME_SINGLE);
    assign same_key  = is_single && (frame_code == key_code_q);

    // Debounce FSM; advances only on the cycle a frame closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cand_q        <= '0;
            cnt_q         <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_done) begin
                case (state_q)
                    ST_IDLE: begin
                        if (is_single) begin
                            cand_q <= frame_code;
                            if (DF_C == CNT_W'(1)) begin
                                state_q       <= ST_PRESSED;
                                key_code_q    <= frame_code;
                                key_valid_q   <= 1'b1;
                                key_pressed_q <= 1'b1;
                                cnt_q         <= '0;
                            end else begin
                                state_q <= ST_CONFIRM;
                                cnt_q   <= CNT_W'(1);
                            end
                        end
                    end
                    ST_CONFIRM: begin
                        if (is_single && (frame_code == cand_q)) begin
                            if (cnt_inc == DF_C) begin
                                state_q       <= ST_PRESSED;
                                key_code_q    <= frame_code;
                                key_valid_q   <= 1'b1;
                                key_pressed_q <= 1'b1;
                                cnt_q         <= '0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else if (is_single) begin
                            cand_q <= frame_code;
                            cnt_q  <= CNT_W'(1);
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (!same_key) begin
                            if (is_none && (DF_C == CNT_W'(1))) begin
                                state_q       <= ST_IDLE;
                                key_pressed_q <= 1'b0;
                                cnt_q         <= '0;
                            end else begin
                                state_q <= ST_RELEASE;
                                cnt_q   <= is_none ? CNT_W'(1) : CNT_W'(0);
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (is_none) begin
                            if (cnt_inc >= DF_C) begin
                                state_q       <= ST_IDLE;
                                key_pressed_q <= 1'b0;
                                cnt_q         <= '0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else if (same_key) begin
                            state_q <= ST_PRESSED;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic       scan_tick;
    logic [3:0] keyboard_row;
    logic [3:0] keyboard_col;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_pressed;

    logic [15:0] key_mask;
    int          checks;
    int          failures;
    int          pulse_cnt;
    int          p0;
    logic        kv;

    keypad_scanner #(.DEBOUNCE_FRAMES(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .scan_tick    (scan_tick),
        .keyboard_row (keyboard_row),
        .keyboard_col (keyboard_col),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_pressed  (key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row r pulled low when a closed key sits on a column driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            keyboard_row[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4 + c] && !keyboard_col[c]) keyboard_row[r] = 1'b0;
            end
        end
    end

    initial pulse_cnt = 0;
    always @(negedge clk) begin
        if (key_valid === 1'b1) pulse_cnt = pulse_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One scan_tick, 8 clk period; kv_o is key_valid just after the ticking edge.
    task automatic tick_once(output logic kv_o);
        @(posedge clk);
        #1 scan_tick = 1'b1;
        @(posedge clk);
        #1 kv_o = key_valid;
        scan_tick = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic do_frame(input logic [15:0] keys, output logic kv_o);
        logic k;
        key_mask = keys;
        for (int t = 0; t < 4; t++) tick_once(k);
        kv_o = k;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_col", 32'(keyboard_col), 32'h e);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_pressed", 32'(key_pressed), 32'h0);
        chk("rst_code", 32'(key_code), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_col;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        scan_tick = 1'b0;
        key_mask  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("init_col", 32'(keyboard_col), 32'h e);
        chk("init_valid", 32'(key_valid), 32'h0);
        chk("init_pressed", 32'(key_pressed), 32'h0);
        chk("init_code", 32'(key_code), 32'h0);
        rst = 1'b0;

        // Column walk over one empty frame
        for (int t = 0; t < 4; t++) begin
            tick_once(kv);
            exp_col = ~(4'b0001 << ((t + 1) % 4));
            chk("col_walk", 32'(keyboard_col), 32'(exp_col));
        end

        // Key 6 held 5 frames
        p0 = pulse_cnt;
        for (int f = 1; f <= 5; f++) begin
            do_frame(16'h0040, kv);
            chk("k6_valid_at_close", 32'(kv), (f == 3) ? 32'h1 : 32'h0);
        end
        chk("k6_pulses", 32'(pulse_cnt - p0), 32'h1);
        chk("k6_code", 32'(key_code), 32'h6);
        chk("k6_pressed", 32'(key_pressed), 32'h1);
        do_frame(16'h0000, kv);
        do_frame(16'h0000, kv);
        chk("k6_rel_partial", 32'(key_pressed), 32'h1);
        do_frame(16'h0000, kv);
        chk("k6_released", 32'(key_pressed), 32'h0);
        chk("k6_code_hold", 32'(key_code), 32'h6);

        // Bounce: 2 present, 1 absent, 3 present
        p0 = pulse_cnt;
        do_frame(16'h0040, kv); chk("bnc_f1", 32'(kv), 32'h0);
        do_frame(16'h0040, kv); chk("bnc_f2", 32'(kv), 32'h0);
        do_frame(16'h0000, kv); chk("bnc_gap", 32'(kv), 32'h0);
        do_frame(16'h0040, kv); chk("bnc_f3", 32'(kv), 32'h0);
        do_frame(16'h0040, kv); chk("bnc_f4", 32'(kv), 32'h0);
        do_frame(16'h0040, kv); chk("bnc_f5", 32'(kv), 32'h1);
        chk("bnc_pulses", 32'(pulse_cnt - p0), 32'h1);
        for (int f = 0; f < 3; f++) do_frame(16'h0000, kv);
        chk("bnc_released", 32'(key_pressed), 32'h0);

        // Two keys on the same row together
        p0 = pulse_cnt;
        for (int f = 0; f < 6; f++) do_frame(16'h0003, kv);
        chk("multi_pulses", 32'(pulse_cnt - p0), 32'h0);
        chk("multi_pressed", 32'(key_pressed), 32'h0);
        do_frame(16'h0000, kv);

        // Key 5 confirmed, then roll over to key 9
        p0 = pulse_cnt;
        for (int f = 0; f < 3; f++) do_frame(16'h0020, kv);
        chk("k5_valid", 32'(kv), 32'h1);
        chk("k5_code", 32'(key_code), 32'h5);
        do_frame(16'h0220, kv);
        for (int f = 0; f < 6; f++) do_frame(16'h0200, kv);
        chk("roll_pulses", 32'(pulse_cnt - p0), 32'h1);
        chk("roll_pressed", 32'(key_pressed), 32'h1);
        chk("roll_code", 32'(key_code), 32'h5);
        for (int f = 0; f < 3; f++) do_frame(16'h0000, kv);
        chk("roll_released", 32'(key_pressed), 32'h0);
        p0 = pulse_cnt;
        for (int f = 0; f < 3; f++) do_frame(16'h0200, kv);
        chk("k9_valid", 32'(kv), 32'h1);
        chk("k9_code", 32'(key_code), 32'h9);
        chk("k9_pulses", 32'(pulse_cnt - p0), 32'h1);

        // Asynchronous reset mid-frame while a key is pressed
        tick_once(kv);
        tick_once(kv);
        async_reset();
        key_mask = 16'h0000;
        do_frame(16'h0000, kv);

        // Reset during the second confirm frame of key 3
        p0 = pulse_cnt;
        do_frame(16'h0008, kv);
        tick_once(kv);
        tick_once(kv);
        async_reset();
        chk("k3_no_pulse_rst", 32'(pulse_cnt - p0), 32'h0);
        do_frame(16'h0008, kv); chk("k3_f1", 32'(kv), 32'h0);
        do_frame(16'h0008, kv); chk("k3_f2", 32'(kv), 32'h0);
        do_frame(16'h0008, kv); chk("k3_f3", 32'(kv), 32'h1);
        chk("k3_code", 32'(key_code), 32'h3);
        chk("k3_pulses", 32'(pulse_cnt - p0), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
